sm_control_unit: RTL and testbench
==================================

# sm_control_unit

Per-SM fetch/decode/sequence unit sitting directly upstream of the SP core array. It fetches 16-bit instructions from instruction memory, decodes them and broadcasts register indices, ALU opcode, immediate, writeback-mux select and write-enable to every SP core in lock-step. It also sequences data-memory handshakes for loads and stores, and takes branch decisions from the cores' predicate outputs.

## Interface
- `N_CORES`, 1, number of SP cores; sets the width of `p_vec`.
- `PC_W`, 8, program-counter and instruction-address width; legal range 1..12.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle launch pulse; honoured only in IDLE and HALT.
- `done`  out  1  high while in HALT.
- `imem_req`  out  1  instruction-fetch request.
- `imem_addr`  out  PC_W  fetch address.
- `imem_rdata`  in  16  fetched word; valid when `imem_valid`=1.
- `imem_valid`  in  1  fetch-complete strobe.
- `mem_req`  out  1  data-memory request (all cores).
- `mem_we`  out  1  1=store, 0=load; meaningful only with `mem_req`.
- `mem_ack`  in  1  data-memory completion; for loads, core `data_in` is valid in the same cycle.
- `p_vec`  in  N_CORES  per-core predicate bits.
- `core_en`  out  1  core clock enable.
- `x`, `y`, `z`  out  4 each  register indices; `x` = destination/store source, `y` = address register.
- `I`  out  16  immediate value.
- `aluc`  out  4  ALU opcode.
- `s2`  out  2  writeback select: 0=`I`, 1=`data_in`, 2=ALU result.
- `reg_we`  out  1  register-file write enable.

## Operation
- Instruction format: [15:12] op, [11:8] x, [7:4] y, [3:0] z.
- Opcodes:
  - 0x0–0x9: ALU op, `aluc`=op.
  - 0xA: LDI; the immediate is the next word.
  - 0xB: LD.
  - 0xC: ST.
  - 0xD: BR; target = instr[PC_W-1:0].
  - 0xE: BRP; branch if |`p_vec`, same target.
  - 0xF: HALT.
- State machine:
  - IDLE: `start` → FETCH, PC=0.
  - FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_valid`: IR←`imem_rdata`, PC←PC+1, → EXEC.
  - EXEC:
    - ALU op: `reg_we`=1, `s2`=2 → FETCH.
    - LDI → IMM.
    - LD/ST → MEM.
    - BR: PC←target → FETCH.
    - BRP: PC←target if taken, else unchanged → FETCH.
    - HALT → HALT.
  - IMM: fetch at PC. On `imem_valid`: `I`←`imem_rdata`, PC←PC+1 → WBI.
  - WBI: `reg_we`=1, `s2`=0 → FETCH.
  - MEM: `mem_req`=1, `mem_we`=(op==ST). On `mem_ack`: for LD, `reg_we`=1 and `s2`=1 in that cycle; then → FETCH.
  - HALT: `done`=1. `start` → FETCH with PC=0.
- `x`, `y`, `z` and `aluc` are driven from the registered IR and hold between instructions.
- `reg_we`, `mem_req` and `imem_req` are asserted only in the states listed above.
- `core_en`=1 in every state except IDLE and HALT.
- PC increments modulo 2^PC_W. An LDI at the last address fetches its immediate from address 0.
- Branch target bits above PC_W are ignored.

## Timing
- Reset (async, `reset`=0): state=IDLE, PC=0, IR=0, `I`=0. All outputs are 0, including `s2`, `done` and `core_en`.
- Reset asserted mid-operation aborts any pending imem or mem handshake immediately. No `reg_we` is issued after reset assertion.
- Zero-wait-state fetch gives these latencies:
  - ALU, BR and BRP: 2 cycles per instruction.
  - LDI: 4 cycles.
  - LD/ST: 3 + (cycles until `mem_ack`).
- Requests are held level until their strobe. A strobe arriving in the same cycle as the request completes that cycle.
- Strobes outside their waiting state are ignored.
- `p_vec` is sampled in the EXEC cycle of BRP only.
- `start` while running is ignored. `start` coincident with reset release is ignored.

## Configuration
- `SMCTRL_PRED_BRANCH_EN` defined: BRP (0xE) branches on |`p_vec`.
- Undefined: 0xE decodes as a no-op (EXEC → FETCH, PC unchanged), and `p_vec` is unused.

## Test plan
- Reset, then `start`; imem holds 0x3123, then 0xF000, with `imem_valid` tied high. Required: `reg_we` pulses once with `x`=1, `y`=2, `z`=3, `aluc`=3, `s2`=2; `done`=1 on cycle 5.
- LDI sequence 0xA500, 0xBEEF with the immediate on a 2-cycle `imem_valid` delay. Required: WBI cycle shows `I`=0xBEEF, `s2`=0, `x`=5, `reg_we`=1; PC=2 afterwards.
- LD (0xB140) with `mem_ack` delayed 3 cycles. Required: `mem_req`=1, `mem_we`=0 for 4 cycles; `reg_we`=1 with `s2`=1 only in the ack cycle. A ST (0xC140) repeat shows `mem_we`=1 and no `reg_we`.
- BRP to 0x10 with `N_CORES`=4.
  - `p_vec`=0000: next fetch address is PC+1.
  - `p_vec`=0100: next fetch address is 0x10.
  - Macro undefined: next fetch address is PC+1 regardless of `p_vec`.
- `PC_W`=2 with an LDI at address 3. Required: immediate fetched from address 0; BR target 0xFFE yields address 2.
- Assert `reset` in MEM while `mem_req`=1. Required: all outputs 0 asynchronously; after release, no activity until `start`.

Source files
------------

// File: rtl/sm_ctrl_if.sv
// sm_ctrl_if: instruction-fetch, data-memory and core-broadcast signals of one SM control unit.
interface sm_ctrl_if #(
   parameter int PC_W    = 8,
   parameter int N_CORES = 1
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [15:0]        imem_rdata;
   logic               imem_valid;
   logic               mem_req;
   logic               mem_we;
   logic               mem_ack;
   logic [N_CORES-1:0] p_vec;
   logic               core_en;
   logic [3:0]         x, y, z;
   logic [15:0]        I;
   logic [3:0]         aluc;
   logic [1:0]         s2;
   logic               reg_we;
   modport master (
      output imem_req, imem_addr, mem_req, mem_we, core_en, x, y, z, I, aluc, s2, reg_we,
      input  imem_rdata, imem_valid, mem_ack, p_vec
   );
   modport slave (
      input  imem_req, imem_addr, mem_req, mem_we, core_en, x, y, z, I, aluc, s2, reg_we,
      output imem_rdata, imem_valid, mem_ack, p_vec
   );
endinterface

// File: rtl/sm_control_unit.sv
// sm_control_unit: per-SM fetch/decode/sequence unit broadcasting decoded fields to the SP cores.
// Define SMCTRL_PRED_BRANCH_EN to make BRP (0xE) branch on |p_vec; otherwise 0xE is a no-op.
module sm_control_unit #(
   parameter int N_CORES = 1,
   parameter int PC_W    = 8
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      start,
   output logic      done,
   sm_ctrl_if.master bus
);
   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, EXEC = 3'd2, IMM = 3'd3,
                          WBI = 3'd4, MEM = 3'd5, HALT = 3'd6;
   logic [2:0]      st;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir, imm;
   logic [3:0]      op;
   logic            armed, taken, alu, ld_ack;
   assign op = ir[15:12];
`ifdef SMCTRL_PRED_BRANCH_EN
   assign taken = |bus.p_vec[N_CORES-1:0];
`else
   assign taken = 1'b0 & (|bus.p_vec[N_CORES-1:0]);
`endif
   // armed blocks a start pulse that coincides with reset release
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         st    <= IDLE;
         pc    <= '0;
         ir    <= '0;
         imm   <= '0;
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (st)
            IDLE, HALT: if (start && armed) begin
               st <= FETCH;
               pc <= '0;
            end
            FETCH: if (bus.imem_valid) begin
               ir <= bus.imem_rdata;
               pc <= pc + PC_W'(1);
               st <= EXEC;
            end
            EXEC: begin
               st <= op == 4'hA ? IMM : (op == 4'hB || op == 4'hC) ? MEM : op == 4'hF ? HALT : FETCH;
               if (op == 4'hD || (op == 4'hE && taken)) pc <= ir[PC_W-1:0];
            end
            IMM: if (bus.imem_valid) begin
               imm <= bus.imem_rdata;
               pc  <= pc + PC_W'(1);
               st  <= WBI;
            end
            WBI: st <= FETCH;
            MEM: if (bus.mem_ack) st <= FETCH;
            default: st <= IDLE;
         endcase
      end
   assign alu           = st == EXEC && op < 4'hA;
   assign ld_ack        = st == MEM && op == 4'hB && bus.mem_ack;
   assign bus.imem_req  = st == FETCH || st == IMM;
   assign bus.imem_addr = pc;
   assign bus.mem_req   = st == MEM;
   assign bus.mem_we    = st == MEM && op == 4'hC;
   assign bus.reg_we    = alu || st == WBI || ld_ack;
   assign bus.s2        = alu ? 2'd2 : ld_ack ? 2'd1 : 2'd0;
   assign bus.core_en   = st != IDLE && st != HALT;
   assign bus.x         = ir[11:8];
   assign bus.y         = ir[7:4];
   assign bus.z         = ir[3:0];
   assign bus.aluc      = op;
   assign bus.I         = imm;
   assign done          = st == HALT;
endmodule

// File: tb/tb_sm_control_unit.sv
// tb_sm_control_unit: random programs checked against an instruction-level model, plus directed cases.
module tb_sm_control_unit;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, sstart = 1'b0;
   logic done, sdone;
   always #5 clk = ~clk;
   sm_ctrl_if #(.PC_W(8), .N_CORES(4)) bus ();
   sm_ctrl_if #(.PC_W(2), .N_CORES(1)) sbus ();
   sm_control_unit #(.N_CORES(4), .PC_W(8)) dut (.clk(clk), .reset(reset), .start(start), .done(done), .bus(bus));
   sm_control_unit #(.N_CORES(1), .PC_W(2)) sdut (.clk(clk), .reset(reset), .start(sstart), .done(sdone), .bus(sbus));
`ifdef SMCTRL_PRED_BRANCH_EN
   localparam bit PRED = 1'b1;
`else
   localparam bit PRED = 1'b0;
`endif
   typedef struct packed {logic [15:0] ins; logic [1:0] s2; logic [15:0] val;} wr_t;
   logic [15:0] mem [256];
   logic [15:0] smem [4];
   logic [7:0]  fetch_q [$];
   wr_t         wr_q [$];
   logic [15:0] mem_q [$];
   logic [1:0]  saddr_q [$];
   int total = 0, bad = 0;
   int imin = 0, imax = 0, mmin = 0, mmax = 0, we_cnt = 0, mreq_cnt = 0;
   logic mwe_seen = 1'b0, active = 1'b0;
   logic [15:0] last_i = '0, s_i = '0;
   logic [3:0]  last_x = '0;
   logic [1:0]  last_s2 = '0;
   logic [7:0]  last_faddr = '0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", n, a, e);
      end
   endtask
   task automatic unexpected(input string n);
      total++;
      bad++;
      $display("FAIL %s act=1 exp=0", n);
   endtask
   task automatic chk_zero(input string n);
      chk({n, "_ctl"}, 32'({bus.imem_req, bus.imem_addr, bus.mem_req, bus.mem_we, bus.core_en,
                            bus.reg_we, bus.s2, done}), 0);
      chk({n, "_dec"}, 32'({bus.x, bus.y, bus.z, bus.aluc, bus.I}), 0);
   endtask
   task automatic fill();
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
   endtask

   // instruction-level reference: expected fetch addresses, register writes and memory ops
   task automatic model(input logic [3:0] pv);
      logic [7:0] pc;
      logic [15:0] ins;
      pc = '0;
      fetch_q.delete();
      wr_q.delete();
      mem_q.delete();
      for (int s = 0; s < 300; s++) begin
         fetch_q.push_back(pc);
         ins = mem[pc];
         pc++;
         if (ins[15:12] == 4'hF) break;
         case (ins[15:12])
            4'hA: begin
               fetch_q.push_back(pc);
               wr_q.push_back('{ins, 2'd0, mem[pc]});
               pc++;
            end
            4'hB: begin
               mem_q.push_back(ins);
               wr_q.push_back('{ins, 2'd1, 16'h0});
            end
            4'hC: mem_q.push_back(ins);
            4'hD: pc = ins[7:0];
            4'hE: if (PRED && pv != 0) pc = ins[7:0];
            default: wr_q.push_back('{ins, 2'd2, 16'h0});
         endcase
      end
   endtask

   // forward-only branches and non-branch immediates guarantee every program halts
   task automatic gen();
      int len, i;
      logic [3:0] op;
      len = $urandom_range(24, 4);
      i = 0;
      fill();
      while (i < len - 1) begin
         op = 4'($urandom_range(14, 0));
         if (op == 4'hA && i + 1 < len - 1) begin
            mem[i] = {op, 12'($urandom)};
            mem[i+1] = {4'($urandom_range(12, 0)), 12'($urandom)};
            i += 2;
         end else if (op == 4'hD || op == 4'hE) begin
            mem[i] = {op, 4'($urandom), 8'($urandom_range(len - 1, i + 1))};
            i++;
         end else begin
            mem[i] = {op == 4'hA ? 4'h1 : op, 12'($urandom)};
            i++;
         end
      end
   endtask

   task automatic run_prog(input logic [3:0] pv, output int n);
      bus.p_vec = pv;
      model(pv);
      we_cnt = 0;
      mreq_cnt = 0;
      mwe_seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      active = 1'b1;
      n = 1;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!done) unexpected("timeout");
      #3;
      chk("fetch_left", 32'(fetch_q.size()), 0);
      chk("wr_left", 32'(wr_q.size()), 0);
      chk("mem_left", 32'(mem_q.size()), 0);
   endtask

   initial begin
      int iw, mw, il, ml;
      iw = 0; mw = 0; il = 0; ml = 0;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = '0;
      bus.mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.imem_req) begin
            if (iw == 0) il = $urandom_range(imax, imin);
            bus.imem_valid = iw == il;
            bus.imem_rdata = mem[bus.imem_addr];
            iw = bus.imem_valid ? 0 : iw + 1;
         end else begin
            bus.imem_valid = 1'b0;
            iw = 0;
         end
         if (bus.mem_req) begin
            if (mw == 0) ml = $urandom_range(mmax, mmin);
            bus.mem_ack = mw == ml;
            mw = bus.mem_ack ? 0 : mw + 1;
         end else begin
            bus.mem_ack = 1'b0;
            mw = 0;
         end
      end
   end

   initial begin
      sbus.imem_valid = 1'b0;
      sbus.imem_rdata = '0;
      sbus.mem_ack = 1'b0;
      sbus.p_vec = '0;
      forever begin
         @(negedge clk);
         sbus.imem_valid = sbus.imem_req;
         sbus.imem_rdata = smem[sbus.imem_addr];
         #1;
         if (sbus.imem_valid) saddr_q.push_back(sbus.imem_addr);
         if (sbus.reg_we) s_i = sbus.I;
      end
   end

   initial begin
      wr_t e;
      logic [15:0] m;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            if (bus.imem_req && bus.imem_valid) begin
               last_faddr = bus.imem_addr;
               if (fetch_q.size() == 0) unexpected("fetch_extra");
               else chk("fetch_addr", 32'(bus.imem_addr), 32'(fetch_q.pop_front()));
            end
            if (bus.reg_we) begin
               we_cnt++;
               last_i = bus.I;
               last_x = bus.x;
               last_s2 = bus.s2;
               if (wr_q.size() == 0) unexpected("we_extra");
               else begin
                  e = wr_q.pop_front();
                  chk("we_x", 32'(bus.x), 32'(e.ins[11:8]));
                  chk("we_s2", 32'(bus.s2), 32'(e.s2));
                  if (e.s2 == 2'd0) chk("we_imm", 32'(bus.I), 32'(e.val));
                  if (e.s2 == 2'd1) chk("ld_ack", 32'(bus.mem_ack), 1);
                  if (e.s2 == 2'd2) chk("alu_dec", 32'({bus.aluc, bus.y, bus.z}), 32'({e.ins[15:12], e.ins[7:0]}));
               end
            end
            if (bus.mem_req) begin
               mreq_cnt++;
               if (bus.mem_ack) begin
                  mwe_seen = mwe_seen | bus.mem_we;
                  if (mem_q.size() == 0) unexpected("mem_extra");
                  else begin
                     m = mem_q.pop_front();
                     chk("mem_op", 32'({bus.mem_we, bus.x, bus.y}), 32'({m[15:12] == 4'hC, m[11:4]}));
                  end
               end
            end
            chk("core_en", 32'(bus.core_en), 32'(active && !done));
         end
      end
   end

   initial begin
      int n;
      int sexp [5];
      sexp = '{0, 3, 0, 1, 2};
      bus.p_vec = '0;
      fill();
      #1;
      chk_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("idle");
      mem[0] = 16'h3123;
      run_prog(4'h0, n);
      chk("alu_cycles", 32'(n), 5);
      chk("alu_we_cnt", 32'(we_cnt), 1);
      chk("alu_x", 32'(last_x), 1);
      fill();
      mem[0] = 16'hA500;
      mem[1] = 16'hBEEF;
      imin = 2;
      imax = 2;
      run_prog(4'h0, n);
      chk("ldi_I", 32'(last_i), 32'h0000BEEF);
      chk("ldi_x", 32'(last_x), 5);
      chk("ldi_s2", 32'(last_s2), 0);
      chk("ldi_pc", 32'(last_faddr), 2);
      fill();
      mem[0] = 16'hB140;
      imin = 0;
      imax = 0;
      mmin = 3;
      mmax = 3;
      run_prog(4'h0, n);
      chk("ld_req_cycles", 32'(mreq_cnt), 4);
      chk("ld_we_cnt", 32'(we_cnt), 1);
      chk("ld_s2", 32'(last_s2), 1);
      chk("ld_mem_we", 32'(mwe_seen), 0);
      mem[0] = 16'hC140;
      run_prog(4'h0, n);
      chk("st_req_cycles", 32'(mreq_cnt), 4);
      chk("st_we_cnt", 32'(we_cnt), 0);
      chk("st_mem_we", 32'(mwe_seen), 1);
      fill();
      mem[0] = 16'hE010;
      run_prog(4'b0000, n);
      chk("brp_not_taken", 32'(last_faddr), 1);
      run_prog(4'b0100, n);
      chk("brp_p4", 32'(last_faddr), PRED ? 16 : 1);
      for (int r = 0; r < 40; r++) begin
         gen();
         imin = 0;
         imax = $urandom_range(3, 0);
         mmin = 0;
         mmax = $urandom_range(4, 0);
         run_prog(4'($urandom), n);
      end
      fill();
      mem[0] = 16'hB140;
      imin = 0;
      imax = 0;
      mmin = 20;
      mmax = 20;
      model(4'h0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      active = 1'b1;
      n = 0;
      while (!bus.mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("mem_reached", 32'(bus.mem_req), 1);
      #1;
      reset = 1'b0;
      active = 1'b0;
      #1;
      chk_zero("async_reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #3;
         chk("quiet_after_reset", 32'({bus.core_en, bus.imem_req, bus.mem_req, bus.reg_we, done}), 0);
      end
      smem[0] = 16'hD003;
      smem[1] = 16'hDFFE;
      smem[2] = 16'hF000;
      smem[3] = 16'hA100;
      saddr_q.delete();
      @(negedge clk);
      sstart = 1'b1;
      @(negedge clk);
      sstart = 1'b0;
      n = 0;
      while (!sdone && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("small_done", 32'(sdone), 1);
      chk("small_nfetch", 32'(saddr_q.size()), 5);
      for (int i = 0; i < 5 && i < saddr_q.size(); i++) chk("small_addr", 32'(saddr_q[i]), 32'(sexp[i]));
      chk("small_imm", 32'(s_i), 32'h0000D003);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
